// File: rtl/da_accum_z5.sv
// Bit-serial distributed-arithmetic shift-accumulator for the Z5 DCT output, MSB plane first.
// Optional macro DA_ROUND_EN: round the result half-up to an integer on a DW+4-bit z_out.
module da_accum_z5 #(
    parameter int DW    = 16,
    parameter int ACC_W = DW + 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        x0,
    input  logic [DW-1:0]        x1,
    input  logic [DW-1:0]        x2,
    output logic                 rom_cs,
    output logic [2:0]           rom_addr,
    input  logic [16:0]          rom_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef DA_ROUND_EN
    output logic signed [DW+3:0] z_out
`else
    output logic signed [ACC_W-1:0] z_out
`endif
);

    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                   state;
    logic [DW-1:0]            sr0, sr1, sr2;
    logic [CW-1:0]            bit_cnt;
    logic                     first_done;
    logic [1:0]               warm_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  rom_r;
    logic signed [ACC_W-1:0]  acc_next;

    assign rom_r = {{(ACC_W-16){rom_data[15]}}, rom_data[15:0]};

    // The sign-bit plane carries negative weight, so it seeds the accumulator with -R.
    always_comb begin
        acc_next = '0;
        if (first_done)
            acc_next = (acc <<< 1) + rom_r;
        else
            acc_next = -rom_r;
    end

`ifdef DA_ROUND_EN
    logic signed [ACC_W-1:0] acc_rnd;
    assign acc_rnd = acc_next + (ACC_W'(1) <<< 13);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr0        <= '0;
            sr1        <= '0;
            sr2        <= '0;
            bit_cnt    <= '0;
            first_done <= 1'b0;
            warm_cnt   <= 2'd0;
            acc        <= '0;
            in_ready   <= 1'b0;
            rom_cs     <= 1'b0;
            rom_addr   <= 3'd0;
            out_valid  <= 1'b0;
            z_out      <= '0;
        end else begin
            // The ROM output is still forced to zero right after reset, so hold off accepts.
            if (warm_cnt != 2'd2)
                warm_cnt <= warm_cnt + 2'd1;

            case (state)
                IDLE: begin
                    rom_cs    <= 1'b0;
                    rom_addr  <= 3'd0;
                    out_valid <= 1'b0;
                    if (in_valid && in_ready) begin
                        sr0        <= x0;
                        sr1        <= x1;
                        sr2        <= x2;
                        bit_cnt    <= CW'(DW - 1);
                        first_done <= 1'b0;
                        in_ready   <= 1'b0;
                        rom_cs     <= 1'b1;
                        rom_addr   <= {x0[DW-1], x1[DW-1], x2[DW-1]};
                        state      <= ACCUM;
                    end else begin
                        in_ready <= (warm_cnt != 2'd0);
                    end
                end

                ACCUM: begin
                    acc        <= acc_next;
                    first_done <= 1'b1;
                    sr0        <= sr0 << 1;
                    sr1        <= sr1 << 1;
                    sr2        <= sr2 << 1;
                    bit_cnt    <= bit_cnt - CW'(1);
                    rom_addr   <= {sr0[DW-2], sr1[DW-2], sr2[DW-2]};
                    if (bit_cnt == '0) begin
                        rom_cs    <= 1'b0;
                        rom_addr  <= 3'd0;
                        out_valid <= 1'b1;
`ifdef DA_ROUND_EN
                        z_out     <= acc_rnd[DW+17:14];
`else
                        z_out     <= acc_next;
`endif
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
